// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// FSM state encoding, port identifiers and read-latency counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int MAX_RD_LATENCY = 7;
    localparam int LAT_CNT_W      = 3;

    // Value loaded into the latency counter when ISSUE hands over to WAIT.
    // Out-of-range latencies are clamped so the counter never wraps.
    function automatic logic [LAT_CNT_W-1:0] lat_preload(input int rd_latency);
        if (rd_latency <= 0)
            return '0;
        if (rd_latency > MAX_RD_LATENCY)
            return LAT_CNT_W'(MAX_RD_LATENCY - 1);
        return LAT_CNT_W'(rd_latency - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. On a tie the port that was not granted last
// wins; the last-grant register only moves when the owner accepts a grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic r_last_grant;
    logic w_pick;

    always_comb begin
        w_pick = i_req[PORT_D];
        if (&i_req)
            w_pick = ~r_last_grant;
    end

    assign o_gnt     = {i_req[PORT_D] & w_pick, i_req[PORT_IF] & ~w_pick};
    assign o_gnt_idx = w_pick;

    // Resetting to DATA lets fetch win the first tie after reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_last_grant <= PORT_D;
        else if (i_update && (|i_req))
            r_last_grant <= w_pick;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports
// of the core using a req/ack handshake and round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rd_data,
    input  logic          d_req,
    input  logic          d_wr_ena,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wr_data,
    output logic          d_ack,
    output logic [DW-1:0] d_rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_ena,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy
);

    localparam logic                 COMB_READ = (RD_LATENCY == 0);
    localparam logic [LAT_CNT_W-1:0] LAT_INIT  = lat_preload(RD_LATENCY);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic                 r_gnt_port;
    logic [LAT_CNT_W-1:0] r_lat_cnt;
    logic [AW-1:0]        r_mem_addr;
    logic                 r_mem_wr_ena;
    logic [DW-1:0]        r_mem_wr_data;
    logic [DW-1:0]        r_if_rd_data;
    logic [DW-1:0]        r_d_rd_data;
    logic                 r_if_ack;
    logic                 r_d_ack;

    logic [1:0]           w_gnt;
    logic                 w_gnt_idx;
    logic                 w_idle;
    logic                 w_grant;
    logic                 w_capture;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && (|w_gnt);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rstb      (rstb),
        .i_req     ({d_req, if_req}),
        .i_update  (w_idle),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant)
                    w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (r_mem_wr_ena) begin
                    w_state_nxt = ACK;
                end else if (COMB_READ) begin
                    w_state_nxt = ACK;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ACK;
                    w_capture   = 1'b1;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= IDLE;
            r_gnt_port    <= PORT_IF;
            r_lat_cnt     <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_ena  <= 1'b0;
            r_mem_wr_data <= '0;
            r_if_rd_data  <= '0;
            r_d_rd_data   <= '0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // ACK is only ever entered from ISSUE/WAIT, so this is a single-cycle pulse.
            r_if_ack <= (w_state_nxt == ACK) && (r_gnt_port == PORT_IF);
            r_d_ack  <= (w_state_nxt == ACK) && (r_gnt_port == PORT_D);

            if (w_grant) begin
                r_gnt_port   <= w_gnt_idx;
                r_mem_addr   <= w_gnt[PORT_D] ? d_addr : if_addr;
                r_mem_wr_ena <= w_gnt[PORT_D] & d_wr_ena;
                if (w_gnt[PORT_D])
                    r_mem_wr_data <= d_wr_data;
            end

            if (r_state == ISSUE) begin
                r_mem_wr_ena <= 1'b0;
                r_lat_cnt    <= LAT_INIT;
            end

            if ((r_state == WAIT) && (r_lat_cnt != '0))
                r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);

            // Only the granted port's read register moves; the other holds.
            if (w_capture) begin
                if (r_gnt_port == PORT_D)
                    r_d_rd_data <= mem_rd_data;
                else
                    r_if_rd_data <= mem_rd_data;
            end
        end
    end

    assign if_ack      = r_if_ack;
    assign d_ack       = r_d_ack;
    assign if_rd_data  = r_if_rd_data;
    assign d_rd_data   = r_d_rd_data;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_ena  = r_mem_wr_ena;
    assign mem_wr_data = r_mem_wr_data;
    assign busy        = (r_state != IDLE);

endmodule
